// File: rtl/main_memory_burst.sv
// -----------------------------------------------------------------------------
// main_memory_burst
//   Main memory sitting behind the cache. It uses a fixed-latency
//   request/response handshake.
//   - A write stores one word and produces no response.
//   - A read that hits in the cache (match=1) is accepted and then dropped.
//   - A read that misses (match=0) returns the whole aligned cache line as a
//     burst. The burst starts with the requested (critical) word and wraps
//     inside the line.
//   The storage array has no reset, so its contents survive rst_n.
//
// Optional feature: define MEM_BYTE_MASK_EN to add the req_be byte-enable
//   input. A write then updates only the bytes whose req_be bit is set.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE only)
//   req_write  in   1 = write one word, 0 = read a line
//   req_addr   in   word address
//   req_wdata  in   write data
//   req_be     in   byte enables (only when MEM_BYTE_MASK_EN is defined)
//   match      in   cache hit flag, sampled with a read request
//   rsp_valid  out  response beat valid (no backpressure)
//   rsp_data   out  response word (registered, holds between bursts)
//   rsp_last   out  final beat of the burst
//   busy       out  engine is not IDLE
// -----------------------------------------------------------------------------
module main_memory_burst #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int LATENCY   = 2,
   parameter int BURST_LEN = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
`ifdef MEM_BYTE_MASK_EN
   input  logic [DATA_W/8-1:0] req_be,
`endif
   input  logic                match,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_last,
   output logic                busy
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   // Mask that selects the word-offset bits inside one line.
   localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BURST_LEN - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]   r_base;
   logic [WAIT_W-1:0]   r_wait;
   logic [BEAT_W-1:0]   r_beat;

   logic                w_accept;
   logic                w_wr_en;
   logic                w_miss;
   logic                w_load;
   logic [BEAT_W-1:0]   w_beat_sel;
   logic [ADDR_W-1:0]   w_rd_addr;

   assign w_accept = req_valid && (r_state == S_IDLE);
   assign w_wr_en  = w_accept && req_write;
   assign w_miss   = w_accept && !req_write && !match;

   // A beat is registered on every edge whose next state is BURST.
   // That covers the WAIT->BURST edge (beat 0) and each non-final BURST edge.
   assign w_load     = (w_state_next == S_BURST);
   assign w_beat_sel = (r_state == S_BURST) ? r_beat + 1'b1 : '0;
   // The offset wraps inside the aligned line. The line base is never
   // touched, so the top line cannot overflow into address 0.
   assign w_rd_addr  = r_base | ((r_ptr + ADDR_W'(w_beat_sel)) & OFF_MASK);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_miss)               w_state_next = S_WAIT;
         S_WAIT:  if (r_wait == '0)         w_state_next = S_BURST;
         S_BURST: if (r_beat == LAST_BEAT)  w_state_next = S_IDLE;
         default:                           w_state_next = S_IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   // These outputs decode the state register directly. An asynchronous reset
   // therefore drops rsp_valid at once, even in the middle of a burst.
   always_comb begin
      req_ready = (r_state == S_IDLE);
      busy      = (r_state != S_IDLE);
      rsp_valid = (r_state == S_BURST);
      rsp_last  = (r_state == S_BURST) && (r_beat == LAST_BEAT);
   end

   // ---------------- burst datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr    <= '0;
         r_base   <= '0;
         r_wait   <= '0;
         r_beat   <= '0;
         rsp_data <= '0;
      end else begin
         if (w_miss) begin
            r_ptr  <= req_addr;
            r_base <= req_addr & ~OFF_MASK;
            r_wait <= WAIT_INIT;
         end else if (r_state == S_WAIT && r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
         end
         if (w_load) begin
            r_beat   <= w_beat_sel;
            rsp_data <= r_mem[w_rd_addr];
         end
      end
   end

   // ---------------- storage array (no reset) ----------------
   // Writes are accepted only in IDLE. A burst therefore never reads a word
   // on the same edge that it is being written.
`ifdef MEM_BYTE_MASK_EN
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (req_be[b]) begin
               r_mem[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[req_addr] <= req_wdata;
      end
   end
`endif

endmodule

// File: tb/tb_main_memory_burst.sv
// -----------------------------------------------------------------------------
// tb_main_memory_burst
//   Scoreboard bench for main_memory_burst.
//   - The stimulus side updates a word-array model of the memory.
//   - For every miss read, it queues the expected beats, each tagged with the
//     cycle in which it must appear.
//   - A monitor on the falling edge pops and compares every beat.
//   - The monitor also checks req_ready and busy against the expected busy
//     window.
// -----------------------------------------------------------------------------
module tb_main_memory_burst;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int LAT = 2;
   localparam int BL  = 4;
   localparam int NB  = DW / 8;

   typedef struct {
      logic [DW-1:0] d;
      bit            last;
      int            c;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
`ifdef MEM_BYTE_MASK_EN
   logic [NB-1:0] req_be;
`endif
   logic          match;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_last;
   logic          busy;

   logic [DW-1:0] model_mem [2**AW];
   beat_t         exp_q[$];
   int            cyc    = 0;
   int            bstart = -100;
   int            bend   = -100;
   int            checks = 0;
   int            errors = 0;

   main_memory_burst #(
      .DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT), .BURST_LEN(BL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
`ifdef MEM_BYTE_MASK_EN
      .req_be   (req_be),
`endif
      .match    (match),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .rsp_last (rsp_last),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: one line per response beat, plus handshake checks every cycle.
   always @(negedge clk) begin
      bit    exp_busy;
      beat_t b;
      if (rst_n === 1'b1) begin
         exp_busy = (cyc >= bstart) && (cyc <= bend);
         check("req_ready", DW'(req_ready), DW'(!exp_busy));
         check("busy", DW'(busy), DW'(exp_busy));
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat at cycle %0d: got data 0x%0h, expected no beat", cyc, rsp_data);
            end else begin
               b = exp_q.pop_front();
               $display("beat cycle=%0d data=0x%0h last=%0b (exp 0x%0h last=%0b)", cyc, rsp_data, rsp_last, b.d, b.last);
               check("rsp_data", rsp_data, b.d);
               check("rsp_last", DW'(rsp_last), DW'(b.last));
               check("beat_cycle", DW'(cyc), DW'(b.c));
            end
         end else if (exp_q.size() != 0 && exp_q[0].c < cyc) begin
            b = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_beat at cycle %0d: got no beat, expected 0x%0h", cyc, b.d);
         end
      end
   end

   // Issues one request and waits (bounded) for its acceptance.
   // Called at posedge+#1 and returns at posedge+#1 after the accept edge.
   task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit m, input logic [NB-1:0] be);
      int            n;
      int            acc;
      logic [AW-1:0] base;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      match     = m;
`ifdef MEM_BYTE_MASK_EN
      req_be    = be;
`endif
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got req_ready=0 for 200 cycles, expected 1");
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc       = cyc;
      req_valid = 1'b0;
      $display("req cycle=%0d wr=%0b addr=%0d data=0x%0h match=%0b be=%0h", acc, wr, a, d, m, be);
      if (wr) begin
         for (int b = 0; b < NB; b++)
            if (be[b]) model_mem[a][b*8 +: 8] = d[b*8 +: 8];
      end else if (!m) begin
         base = a & ~AW'(BL - 1);
         for (int i = 0; i < BL; i++)
            exp_q.push_back('{model_mem[base | AW'((int'(a) + i) % BL)], (i == BL - 1), acc + LAT + i});
         bstart = acc;
         bend   = acc + LAT + BL - 1;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int             n;
      int             r;
      logic [NB-1:0]  be;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      match     = 1'b0;
`ifdef MEM_BYTE_MASK_EN
      req_be    = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("reset_rsp_valid", DW'(rsp_valid), 0);
      check("reset_rsp_last", DW'(rsp_last), 0);
      check("reset_req_ready", DW'(req_ready), 1);
      check("reset_busy", DW'(busy), 0);
      check("reset_rsp_data", rsp_data, 0);
      rst_n = 1'b1;

      // Fill the whole array so every later read has a known expected value.
      for (int a = 0; a < 2**AW; a++)
         do_req(1'b1, AW'(a), $urandom, 1'b0, '1);

      // Line 8..11, then a miss from the first word and from the middle word.
      for (int i = 0; i < 4; i++)
         do_req(1'b1, AW'(8 + i), DW'(32'h11 + i), 1'b0, '1);
      do_req(1'b0, AW'(8), '0, 1'b0, '1);
      wait_drain();
      do_req(1'b0, AW'(10), '0, 1'b0, '1);
      wait_drain();

      // Hit drop: no beats, ready stays high.
      do_req(1'b0, AW'(8), '0, 1'b1, '1);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1;

      // A write held during a top-of-memory burst must not be accepted.
      do_req(1'b0, AW'(31), '0, 1'b0, '1);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = AW'(29);
      req_wdata = 32'hDEADBEEF;
      match     = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(rsp_valid && rsp_last) && n < 50);
      req_valid = 1'b0;
      wait_drain();
      do_req(1'b0, AW'(29), '0, 1'b0, '1);
      wait_drain();

`ifdef MEM_BYTE_MASK_EN
      do_req(1'b1, AW'(3), 32'hAABBCCDD, 1'b0, '1);
      do_req(1'b1, AW'(3), 32'h11223344, 1'b0, 4'b0101);
      do_req(1'b1, AW'(3), 32'h55667788, 1'b0, 4'b0000);
      do_req(1'b0, AW'(3), '0, 1'b0, '1);
      wait_drain();
      check("byte_mask_model", model_mem[3], 32'hAA22CC44);
`endif

      // Reset in the middle of a burst.
      do_req(1'b0, AW'(5), '0, 1'b0, '1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 20);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midburst_rst_rsp_valid", DW'(rsp_valid), 0);
      check("midburst_rst_busy", DW'(busy), 0);
      exp_q.delete();
      bstart = -100;
      bend   = -100;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", DW'(req_ready), 1);
      check("post_rst_busy", DW'(busy), 0);
      @(posedge clk);
      #1;
      // Memory must have survived the reset.
      do_req(1'b0, AW'(6), '0, 1'b0, '1);
      wait_drain();

      // Randomized mix of writes, misses and hits.
      for (int k = 0; k < 80; k++) begin
         r  = $urandom_range(0, 9);
`ifdef MEM_BYTE_MASK_EN
         be = NB'($urandom);
`else
         be = '1;
`endif
         if (r < 4)
            do_req(1'b1, AW'($urandom_range(0, 2**AW - 1)), $urandom, 1'b0, be);
         else if (r < 7)
            do_req(1'b0, AW'($urandom_range(0, 2**AW - 1)), '0, 1'b0, '1);
         else
            do_req(1'b0, AW'($urandom_range(0, 2**AW - 1)), '0, 1'b1, '1);
      end
      wait_drain();
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
